// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for the multi-cycle FP adder.
// The master side (ALU top level) drives operands and out_ready.
interface fp_add_sequencer_if;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] sum;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   modport master (
      output a, b, in_valid, out_ready,
      input  in_ready, sum, out_valid, busy
   );

   modport slave (
      input  a, b, in_valid, out_ready,
      output in_ready, sum, out_valid, busy
   );
endinterface

// File: rtl/fp_add_sequencer.sv
// Sequential IEEE-754 single-precision adder: unpack, stepwise align,
// add/sub, one-bit-per-cycle normalise, pack. Truncating, no rounding.
module fp_add_sequencer #(
   parameter int ALIGN_STEP = 4
) (
   input logic               clk,
   input logic               reset,
   fp_add_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE
   } state_t;

   localparam logic [7:0]  STEP    = 8'(ALIGN_STEP);
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX = 8'd254;

   state_t      state, state_nxt;

   logic [31:0] a_q, b_q;
   logic        sign_x, sign_y;
   logic [7:0]  e_q;
   logic [24:0] mx_q, my_q;
   logic [7:0]  diff_q;
   logic [24:0] m_q;
   logic        force_q;
   logic [31:0] force_val_q;
   logic [31:0] sum_q;

   // Unpack: X is the operand with the larger {exp,frac} magnitude.
   logic        b_gt;
   logic [31:0] op_x, op_y;
   logic [7:0]  ex, ey, raw_diff;
   logic [24:0] man_x, man_y;
   logic        far, nan_in;

   always_comb begin
      b_gt     = b_q[30:0] > a_q[30:0];
      op_x     = b_gt ? b_q : a_q;
      op_y     = b_gt ? a_q : b_q;
      ex       = op_x[30:23];
      ey       = op_y[30:23];
      man_x    = (ex == 8'd0) ? 25'd0 : {2'b01, op_x[22:0]};
      man_y    = (ey == 8'd0) ? 25'd0 : {2'b01, op_y[22:0]};
      raw_diff = ex - ey;
      far      = raw_diff >= 8'd25;
      nan_in   = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
   end

   logic [7:0]  step;
   logic [24:0] add_m;

   always_comb begin
      step  = (diff_q > STEP) ? STEP : diff_q;
      add_m = (sign_x == sign_y) ? (mx_q + my_q) : (mx_q - my_q);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (bus.in_valid) state_nxt = UNPACK;
         UNPACK: state_nxt = nan_in ? PACK : ALIGN;
         ALIGN:  if (diff_q == 8'd0) state_nxt = ADD;
         ADD:    state_nxt = (add_m == 25'd0) ? PACK : NORM;
         NORM:   if (m_q[24] || m_q[23] || (e_q == 8'd1)) state_nxt = PACK;
         PACK:   state_nxt = DONE;
         DONE:   if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         sign_x      <= 1'b0;
         sign_y      <= 1'b0;
         e_q         <= '0;
         mx_q        <= '0;
         my_q        <= '0;
         diff_q      <= '0;
         m_q         <= '0;
         force_q     <= 1'b0;
         force_val_q <= '0;
         sum_q       <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_q     <= bus.a;
               b_q     <= bus.b;
               force_q <= 1'b0;
            end
            UNPACK: begin
               sign_x <= op_x[31];
               sign_y <= op_y[31];
               e_q    <= ex;
               mx_q   <= man_x;
               my_q   <= far ? 25'd0 : man_y;
               diff_q <= far ? 8'd0 : raw_diff;
               if (nan_in) begin
                  force_q     <= 1'b1;
                  force_val_q <= QNAN;
               end
            end
            ALIGN: if (diff_q != 8'd0) begin
               my_q   <= my_q >> step;
               diff_q <= diff_q - step;
            end
            ADD: begin
               m_q <= add_m;
               if (add_m == 25'd0) begin
                  force_q     <= 1'b1;
                  force_val_q <= 32'h0000_0000;
               end
            end
            // Exactly one normalisation action per cycle.
            NORM: begin
               if (m_q[24]) begin
                  if (e_q == EXP_MAX) begin
                     force_q     <= 1'b1;
                     force_val_q <= {sign_x, 8'hFF, 23'd0};
                  end else begin
                     m_q <= m_q >> 1;
                     e_q <= e_q + 8'd1;
                  end
               end else if (!m_q[23]) begin
                  if (e_q == 8'd1) begin
                     force_q     <= 1'b1;
                     force_val_q <= {sign_x, 31'd0};
                  end else begin
                     m_q <= m_q << 1;
                     e_q <= e_q - 8'd1;
                  end
               end
            end
            PACK: sum_q <= force_q ? force_val_q : {sign_x, e_q, m_q[22:0]};
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.sum       = sum_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed-vector bench for fp_add_sequencer: results, latencies,
// backpressure and mid-operation reset, on ALIGN_STEP=4 and 24 instances.
module tb_fp_add_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fp_add_sequencer_if bus4 ();
   fp_add_sequencer_if bus24 ();

   fp_add_sequencer #(.ALIGN_STEP(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
   fp_add_sequencer #(.ALIGN_STEP(24)) u_dut24 (.clk(clk), .reset(reset), .bus(bus24.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic v);
      if (sel) begin bus24.a = a; bus24.b = b; bus24.in_valid = v; end
      else     begin bus4.a  = a; bus4.b  = b; bus4.in_valid  = v; end
   endtask

   function automatic logic ov(input bit sel);
      return sel ? bus24.out_valid : bus4.out_valid;
   endfunction

   // Accept on the next edge, count edges until out_valid, check sum and latency.
   task automatic do_op(input string tag, input bit sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_sum, input int exp_lat);
      int lat;
      drive(sel, a, b, 1'b1);
      @(posedge clk); #1;
      drive(sel, 32'd0, 32'd0, 1'b0);
      lat = 0;
      while (!ov(sel) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 100) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({tag, "_sum"}, sel ? bus24.sum : bus4.sum, exp_sum);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if ((sel ? bus24.out_ready : bus4.out_ready) == 1'b1) begin
         @(posedge clk); #1;
         chk({tag, "_rdy_after"}, {31'd0, sel ? bus24.in_ready : bus4.in_ready}, 32'd1);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b1, 32'd0, 32'd0, 1'b0);
      bus4.out_ready  = 1'b1;
      bus24.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_in_ready",  {31'd0, bus4.in_ready},  32'd1);
      chk("rst_busy",      {31'd0, bus4.busy},      32'd0);
      chk("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      chk("rst_sum",       bus4.sum,                32'd0);

      do_op("one_one",   1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5);
      do_op("small_s4",  1'b0, 32'h3F80_0000, 32'h3A80_0000, 32'h3F80_2000, 8);
      do_op("small_s24", 1'b1, 32'h3F80_0000, 32'h3A80_0000, 32'h3F80_2000, 6);
      do_op("cancel",    1'b0, 32'h3FC0_0000, 32'hBFA0_0000, 32'h3E80_0000, 7);
      do_op("swapped",   1'b0, 32'hBFA0_0000, 32'h3FC0_0000, 32'h3E80_0000, 7);
      do_op("zero",      1'b0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4);
      do_op("ovf_inf",   1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 5);
      do_op("nan",       1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2);

      // Backpressure: result must hold while in_valid pulses are ignored.
      bus4.out_ready = 1'b0;
      do_op("bp", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h4000_0000, 32'h4000_0000, 1'b1);
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, bus4.out_valid}, 32'd1);
         chk("bp_sum",   bus4.sum,                32'h4000_0000);
         chk("bp_rdy",   {31'd0, bus4.in_ready},  32'd0);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_rdy",   {31'd0, bus4.in_ready},  32'd1);
      chk("bp_idle_valid", {31'd0, bus4.out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("bp_no_second",  {31'd0, bus4.busy},      32'd0);

      // Reset while aligning 1.0 + 2^-10.
      drive(1'b0, 32'h3F80_0000, 32'h3A80_0000, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_rdy",   {31'd0, bus4.in_ready},  32'd1);
      chk("mid_rst_valid", {31'd0, bus4.out_valid}, 32'd0);
      chk("mid_rst_busy",  {31'd0, bus4.busy},      32'd0);
      chk("mid_rst_sum",   bus4.sum,                32'd0);
      do_op("post_rst", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
